// File: rtl/root_calc_pkg.sv
// Shared types and constants for the root calculator datapath.
package root_calc_pkg;

  localparam int FP_W   = 32;
  localparam int MANT_W = 24;          // hidden bit + 23 fraction bits, Q1.23
  localparam int R_W    = 27;          // reciprocal estimate, Q1.26
  localparam int D_W    = R_W + 1;     // m*r and 2-m*r, Q2.26
  localparam int BIAS   = 127;

  // Reciprocal exponent offsets: 2*BIAS for an exact power of two,
  // 2*BIAS-1 when the mantissa reciprocal 1/m lies in (0.5, 1).
  localparam logic [7:0] EXP_253 = 8'(2 * BIAS - 1);
  localparam logic [7:0] EXP_254 = 8'(2 * BIAS);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEED = 3'd1,
    ST_MUL1 = 3'd2,
    ST_MUL2 = 3'd3,
    ST_PACK = 3'd4
  } state_t;

  // Linear seed r0 = 1.5 - m/2 in Q1.26; m/2 in Q1.26 is m (Q1.23) shifted left by 2.
  function automatic logic [R_W-1:0] seed_r(input logic [MANT_W-1:0] m);
    return 27'h6000000 - {1'b0, m, 2'b00};
  endfunction

endpackage

// File: rtl/recip_nr_iter.sv
// One Newton-Raphson half-step for 1/m. A single multiplier is shared:
//   sel_rd = 0 : t = m*r (Q2.26, truncated), d_next = 2 - t
//   sel_rd = 1 : r_next = r*d (Q1.26, truncated)
// Both operands are aligned to Q1.26 so one product shift serves both uses.
// d stays below 2 throughout the iteration, so its Q1.26 form carries it exactly.
module recip_nr_iter
  import root_calc_pkg::*;
(
  input  logic              sel_rd,
  input  logic [MANT_W-1:0] m,
  input  logic [R_W-1:0]    r,
  input  logic [R_W-1:0]    d,
  output logic [R_W-1:0]    d_next,
  output logic [R_W-1:0]    r_next
);

  logic [R_W-1:0]   op_a;
  logic [2*R_W-1:0] prod;
  logic [D_W-1:0]   t;

  // Shared multiply; product is Q2.52, the >>26 drops to Q2.26 / Q1.26.
  always_comb begin
    op_a   = sel_rd ? d : {m, 3'b000};
    prod   = (2*R_W)'(op_a) * (2*R_W)'(r);
    t      = D_W'(prod >> (R_W - 1));
    d_next = R_W'(28'h8000000 - t);
    r_next = R_W'(prod >> (R_W - 1));
  end

endmodule

// File: rtl/recip_rough_x_seq.sv
// Sequential FP32 reciprocal of the rough root estimate. Runs ITERS
// Newton-Raphson iterations on the mantissa, then packs recip together
// with the captured operands and a one-cycle valid pulse.
//
// Handshake: start is sampled only while idle (busy low); a start seen
// while busy is dropped. busy rises on the accepting edge and falls on
// the edge that raises valid; valid is high for exactly one cycle and
// recip/s_out/x_out/div_zero hold their values until the next result.
module recip_rough_x_seq
  import root_calc_pkg::*;
#(
  parameter int ITERS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in_s,
  input  logic [31:0] rough_x,
  output logic        busy,
  output logic        valid,
  output logic [31:0] recip,
  output logic [31:0] s_out,
  output logic [31:0] x_out,
  output logic        div_zero,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] CNT_LAST = 3'(ITERS - 1);

  state_t            state, state_n;
  logic [2:0]        cnt;
  logic [FP_W-1:0]   x_q, s_q;
  logic [R_W-1:0]    r_q, d_q;
  logic [R_W-1:0]    d_next, r_next;
  logic [MANT_W-1:0] m;
  logic [7:0]        ex;
  logic              sign;
  logic              frac_zero;
  logic [31:0]       pack_recip;
  logic              pack_dz;

  assign m         = {1'b1, x_q[22:0]};
  assign ex        = x_q[30:23];
  assign sign      = x_q[31];
  assign frac_zero = (x_q[22:0] == 23'd0);
  assign dbg_state = state;

  recip_nr_iter u_iter (
    .sel_rd (state == ST_MUL2),
    .m      (m),
    .r      (r_q),
    .d      (d_q),
    .d_next (d_next),
    .r_next (r_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state: one seed cycle, ITERS pairs of MUL1/MUL2, one pack cycle.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_SEED;
      ST_SEED: state_n = ST_MUL1;
      ST_MUL1: state_n = ST_MUL2;
      ST_MUL2: state_n = (cnt == CNT_LAST) ? ST_PACK : ST_MUL1;
      ST_PACK: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Result formatting: specials first, then exact power-of-two, then 2r.
  always_comb begin
    pack_recip = {sign, 31'd0};
    pack_dz    = 1'b0;
    if (ex == 8'd0) begin
      pack_recip = {sign, 8'hFF, 23'd0};
      pack_dz    = 1'b1;
    end else if (ex == 8'hFF) begin
      pack_recip = {sign, 31'd0};
    end else if (frac_zero) begin
      if (ex < EXP_254) pack_recip = {sign, EXP_254 - ex, 23'd0};
    end else begin
      if (ex < EXP_253) pack_recip = {sign, EXP_253 - ex, r_q[24:2]};
    end
  end

  // Operand capture, iteration registers and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 3'd0;
      x_q      <= '0;
      s_q      <= '0;
      r_q      <= '0;
      d_q      <= '0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      recip    <= '0;
      s_out    <= '0;
      x_out    <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x_q <= rough_x;
            s_q <= in_s;
          end
        end
        ST_SEED: begin
          r_q <= seed_r(m);
          cnt <= 3'd0;
        end
        ST_MUL1: d_q <= d_next;
        ST_MUL2: begin
          r_q <= r_next;
          cnt <= cnt + 3'd1;
        end
        ST_PACK: begin
          recip    <= pack_recip;
          div_zero <= pack_dz;
          s_out    <= s_q;
          x_out    <= x_q;
        end
        default: ;
      endcase
      valid <= (state == ST_PACK);
      busy  <= (state_n != ST_IDLE);
    end
  end

endmodule
